// File: rtl/controller_emulator.sv
// Device-side serial controller responder: latches button states and shifts them out active-low.
// Optional per-button debounce is enabled by defining CONTROLLER_EMULATOR_DEBOUNCE_EN.
module controller_emulator #(
  parameter int unsigned NUM_BUTTONS     = 8,
  parameter logic        FILL_BIT        = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_B,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   ctrl_latch,
  input  logic                   ctrl_clk,
  output logic                   ctrl_data_out_B,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned    CW      = $clog2(NUM_BUTTONS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(NUM_BUTTONS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state, state_n;
  logic [NUM_BUTTONS-1:0] shreg, shreg_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   last_shift, done_pend;

  logic [1:0]             latch_sync, clk_sync;
  logic                   clk_d;
  logic [NUM_BUTTONS-1:0] btn_s1, btn_s2, btn_val;
  logic                   latch_s, clk_rise;

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      clk_d      <= 1'b0;
      btn_s1     <= '0;
      btn_s2     <= '0;
    end else begin
      latch_sync <= {latch_sync[0], ctrl_latch};
      clk_sync   <= {clk_sync[0], ctrl_clk};
      clk_d      <= clk_sync[1];
      btn_s1     <= buttons;
      btn_s2     <= btn_s1;
    end
  end

  assign latch_s  = latch_sync[1];
  assign clk_rise = clk_sync[1] & ~clk_d;

`ifdef CONTROLLER_EMULATOR_DEBOUNCE_EN
  localparam int unsigned   DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0]          db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] btn_db;

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      btn_db <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (btn_s2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_db[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign btn_val = btn_db;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
  assign btn_val         = btn_s2;
`endif

  // Latch level has priority over any clock edge seen in the same cycle.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    last_shift = 1'b0;
    if (latch_s) begin
      state_n = LOAD;
      shreg_n = btn_val;
      cnt_n   = '0;
    end else begin
      case (state)
        LOAD:  state_n = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            shreg_n = shreg >> 1;
            cnt_n   = cnt + CW'(1);
            if (cnt == CNT_MAX - CW'(1)) begin
              state_n    = DONE;
              last_shift = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // frame_done is delayed one stage so it lines up with the registered data output.
  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      shreg           <= '0;
      cnt             <= '0;
      done_pend       <= 1'b0;
      frame_done      <= 1'b0;
      ctrl_data_out_B <= 1'b1;
    end else begin
      shreg           <= shreg_n;
      cnt             <= cnt_n;
      done_pend       <= last_shift;
      frame_done      <= done_pend;
      ctrl_data_out_B <= ~((cnt == CNT_MAX) ? FILL_BIT : shreg[0]);
    end
  end

  assign busy = (state == SHIFT);

endmodule
